// File: rtl/encoder_tx_sequencer.sv
// Byte-rate sequencer feeding an 8b/10b encoder: comma preamble, K28.5/D16.2 idle
// pairs, SOP/EOP packet framing and periodic forced comma bursts for receiver re-alignment.
module encoder_tx_sequencer #(
    parameter int ALIGN_COUNT  = 16,
    parameter int ALIGN_PERIOD = 1024,
    parameter int ALIGN_BURST  = 4
) (
    input  logic       SBYTECLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    input  logic       TX_LAST,
    output logic       TX_READY,
    output logic [7:0] ENC_DATA,
    output logic       ENC_K,
    output logic       LINK_UP,
    output logic       UNDERRUN
);

    localparam int ACW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
    localparam int PCW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam int BCW = (ALIGN_BURST > 1) ? $clog2(ALIGN_BURST) : 1;

    localparam logic [ACW-1:0] ALIGN_CNT_LAST  = ACW'(ALIGN_COUNT - 1);
    localparam logic [PCW-1:0] PERIOD_CNT_LAST = PCW'(ALIGN_PERIOD - 1);
    localparam logic [BCW-1:0] BURST_CNT_LAST  = BCW'(ALIGN_BURST - 1);

    localparam logic [7:0] SYM_K28_5 = 8'hBC;
    localparam logic [7:0] SYM_D16_2 = 8'h50;
    localparam logic [7:0] SYM_K27_7 = 8'hFB;
    localparam logic [7:0] SYM_K29_7 = 8'hFD;
    localparam logic [7:0] SYM_K23_7 = 8'hF7;

    typedef enum logic [2:0] {
        ST_ALIGN,
        ST_IDLE_K,
        ST_IDLE_D,
        ST_SOP,
        ST_DATA,
        ST_EOP
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     enc_data_nxt;
    logic           enc_k_nxt;
    logic           underrun_nxt;
    logic           link_up_nxt;
    logic [ACW-1:0] align_cnt, align_cnt_nxt;
    logic [PCW-1:0] period_cnt, period_cnt_nxt;
    logic [BCW-1:0] burst_cnt, burst_cnt_nxt;
    logic           align_pending, align_pending_nxt;

    assign TX_READY = (state == ST_DATA) & ~RESET;

    always_comb begin
        state_nxt         = state;
        enc_data_nxt      = SYM_K28_5;
        enc_k_nxt         = 1'b1;
        underrun_nxt      = 1'b0;
        link_up_nxt       = LINK_UP;
        align_cnt_nxt     = align_cnt;
        period_cnt_nxt    = period_cnt;
        burst_cnt_nxt     = burst_cnt;
        align_pending_nxt = align_pending;

        case (state)
            ST_ALIGN: begin
                if (!ENABLE) begin
                    align_cnt_nxt = '0;
                end else if (align_cnt == ALIGN_CNT_LAST) begin
                    align_cnt_nxt = '0;
                    link_up_nxt   = 1'b1;
                    state_nxt     = ST_IDLE_D;
                end else begin
                    align_cnt_nxt = align_cnt + 1'b1;
                end
            end
            ST_IDLE_K: state_nxt = ST_IDLE_D;
            ST_IDLE_D: begin
                enc_data_nxt = SYM_D16_2;
                enc_k_nxt    = 1'b0;
                if (!ENABLE) begin
                    link_up_nxt = 1'b0;
                    state_nxt   = ST_ALIGN;
                end else if (TX_VALID && !align_pending) begin
                    state_nxt = ST_SOP;
                end else begin
                    state_nxt = ST_IDLE_K;
                end
            end
            ST_SOP: begin
                enc_data_nxt = SYM_K27_7;
                state_nxt    = ST_DATA;
            end
            ST_DATA: begin
                if (TX_VALID) begin
                    enc_data_nxt = TX_DATA;
                    enc_k_nxt    = 1'b0;
                    if (TX_LAST) state_nxt = ST_EOP;
                end else begin
                    // source starved mid-packet: pad with K23.7 and flag it
                    enc_data_nxt = SYM_K23_7;
                    underrun_nxt = 1'b1;
                end
            end
            ST_EOP: begin
                enc_data_nxt = SYM_K29_7;
                state_nxt    = ST_IDLE_K;
            end
            default: state_nxt = ST_ALIGN;
        endcase

        if (align_pending && state == ST_IDLE_D) begin
            if (burst_cnt == BURST_CNT_LAST) align_pending_nxt = 1'b0;
            else                             burst_cnt_nxt     = burst_cnt + 1'b1;
        end

        // period wrap is applied last so it overrides a coincident burst completion
        if (!LINK_UP) begin
            period_cnt_nxt = '0;
        end else if (period_cnt == PERIOD_CNT_LAST) begin
            period_cnt_nxt    = '0;
            align_pending_nxt = 1'b1;
            burst_cnt_nxt     = '0;
        end else begin
            period_cnt_nxt = period_cnt + 1'b1;
        end
    end

    always_ff @(posedge SBYTECLK) begin
        if (RESET) begin
            state         <= ST_ALIGN;
            ENC_DATA      <= SYM_K28_5;
            ENC_K         <= 1'b1;
            LINK_UP       <= 1'b0;
            UNDERRUN      <= 1'b0;
            align_cnt     <= '0;
            period_cnt    <= '0;
            burst_cnt     <= '0;
            align_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            ENC_DATA      <= enc_data_nxt;
            ENC_K         <= enc_k_nxt;
            LINK_UP       <= link_up_nxt;
            UNDERRUN      <= underrun_nxt;
            align_cnt     <= align_cnt_nxt;
            period_cnt    <= period_cnt_nxt;
            burst_cnt     <= burst_cnt_nxt;
            align_pending <= align_pending_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_tx_sequencer.sv
// Bench for encoder_tx_sequencer: directed vector table, randomized traffic checked by a
// symbol-stream grammar model with alignment-window bookkeeping, and reset/enable corner cases.
module tb_encoder_tx_sequencer;

    localparam int ACOUNT = 16;
    localparam int PERIOD = 64;
    localparam int BURST  = 4;

    logic       SBYTECLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_LAST;
    logic       TX_READY;
    logic [7:0] ENC_DATA;
    logic       ENC_K;
    logic       LINK_UP;
    logic       UNDERRUN;

    encoder_tx_sequencer #(
        .ALIGN_COUNT (ACOUNT),
        .ALIGN_PERIOD(PERIOD),
        .ALIGN_BURST (BURST)
    ) dut (
        .SBYTECLK(SBYTECLK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .TX_DATA (TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_LAST (TX_LAST),
        .TX_READY(TX_READY),
        .ENC_DATA(ENC_DATA),
        .ENC_K   (ENC_K),
        .LINK_UP (LINK_UP),
        .UNDERRUN(UNDERRUN)
    );

    always #5 SBYTECLK = ~SBYTECLK;

    typedef struct {
        logic       rst, en, vld, last;
        logic [7:0] data;
        logic [7:0] e_data;
        logic       e_k, e_link, e_rdy, e_und;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int    total = 0;
    int    bad   = 0;
    vec_t  tbl[$];
    beat_t src_q[$];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge SBYTECLK);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic vld,
                                input logic [7:0] d, input logic last, input logic [7:0] ed,
                                input logic ek, input logic el, input logic er, input logic eu);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.data = d; v.last = last;
        v.e_data = ed; v.e_k = ek; v.e_link = el; v.e_rdy = er; v.e_und = eu;
        return v;
    endfunction

    task automatic gen_packet();
        int    len;
        beat_t b;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.last = (i == len - 1);
            src_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    initial begin
        int         phase, cnt50, n, nblocked;
        logic       wrap_seen, hold_sop, prev_vld, cur_vld, rdy_before, found;
        logic [7:0] e_sym;
        logic       e_k, e_last;

        RESET = 1'b1; ENABLE = 1'b0; TX_VALID = 1'b0; TX_LAST = 1'b0; TX_DATA = 8'h00;

        // directed vectors: preamble, 3-byte packet, then a packet with a 2-cycle underrun
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0));
        for (int i = 1; i < ACOUNT; i++) tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h50, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h11, 0, 8'h50, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h11, 0, 8'hFB, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h11, 0, 8'h11, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h22, 0, 8'h22, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h33, 1, 8'h33, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hFD, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h50, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA1, 0, 8'h50, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA1, 0, 8'hFB, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA1, 0, 8'hA1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hF7, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hF7, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 8'hA2, 1, 8'hA2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hFD, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h50, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            RESET = tbl[i].rst; ENABLE = tbl[i].en; TX_VALID = tbl[i].vld;
            TX_DATA = tbl[i].data; TX_LAST = tbl[i].last;
            tick();
            chk($sformatf("tbl%0d_sym", i), {ENC_DATA, ENC_K}, {tbl[i].e_data, tbl[i].e_k});
            chk($sformatf("tbl%0d_link", i), LINK_UP, tbl[i].e_link);
            chk($sformatf("tbl%0d_rdy", i), TX_READY, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_und", i), UNDERRUN, tbl[i].e_und);
        end

        // randomized traffic against the stream model
        RESET = 1'b1; ENABLE = 1'b1; TX_VALID = 1'b0; TX_LAST = 1'b0;
        tick();
        RESET = 1'b0;
        for (int e = 1; e <= ACOUNT; e++) begin
            tick();
            chk("pre_sym", {ENC_DATA, ENC_K}, {8'hBC, 1'b1});
            chk("pre_link", LINK_UP, (e == ACOUNT));
        end
        n = ACOUNT; phase = 1; prev_vld = 0; hold_sop = 0; wrap_seen = 0; cnt50 = 0; nblocked = 0;
        for (int c = 0; c < 900; c++) begin
            if (src_q.size() == 0) gen_packet();
            cur_vld  = ($urandom_range(0, 7) != 0);
            TX_VALID = cur_vld;
            TX_DATA  = src_q[0].data;
            TX_LAST  = src_q[0].last;
            rdy_before = TX_READY;
            tick();
            n++;
            if (cur_vld && rdy_before) void'(src_q.pop_front());

            e_sym = 8'hBC; e_k = 1'b1;
            case (phase)
                0: phase = 1;
                1: begin
                    e_sym = 8'h50; e_k = 1'b0;
                    hold_sop = wrap_seen && (cnt50 < BURST);
                    if (hold_sop && cur_vld) nblocked++;
                    cnt50++;
                    phase = 2;
                end
                2: begin
                    if (prev_vld && !hold_sop) begin e_sym = 8'hFB; phase = 3; end
                    else phase = 1;
                end
                3: begin
                    if (cur_vld) begin
                        chk("exp_q_nonempty", (exp_q.size() != 0), 1'b1);
                        if (exp_q.size() != 0) begin
                            e_sym = exp_q[0].data; e_k = 1'b0; e_last = exp_q[0].last;
                            void'(exp_q.pop_front());
                            if (e_last) phase = 4;
                        end
                    end else begin
                        e_sym = 8'hF7;
                    end
                end
                default: begin e_sym = 8'hFD; phase = 0; end
            endcase
            chk("rnd_sym", {ENC_DATA, ENC_K}, {e_sym, e_k});
            chk("rnd_und", UNDERRUN, (e_sym == 8'hF7 && e_k));
            chk("rnd_link", LINK_UP, 1'b1);
            chk("rnd_rdy", TX_READY, (phase == 3));
            prev_vld = cur_vld;
            if ((n - ACOUNT) % PERIOD == 0) begin wrap_seen = 1; cnt50 = 0; end
        end
        chk("rnd_align_blocked_seen", (nblocked > 0), 1'b1);

        // ENABLE dropped mid-packet: packet completes, one idle pair, back to ALIGN
        ENABLE = 1'b1; TX_VALID = 1'b1; TX_LAST = 1'b1; TX_DATA = 8'h99;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (ENC_DATA == 8'hFB && ENC_K) found = 1;
        end
        chk("t5_sop_seen", found, 1'b1);
        ENABLE = 1'b0; TX_DATA = 8'hB1; TX_LAST = 1'b0;
        tick(); chk("t5_b1", {ENC_DATA, ENC_K}, {8'hB1, 1'b0});
        TX_DATA = 8'hB2; TX_LAST = 1'b1;
        tick(); chk("t5_b2", {ENC_DATA, ENC_K}, {8'hB2, 1'b0});
        TX_VALID = 1'b0; TX_LAST = 1'b0;
        tick(); chk("t5_eop", {ENC_DATA, ENC_K}, {8'hFD, 1'b1});
        tick(); chk("t5_idle_k", {ENC_DATA, ENC_K}, {8'hBC, 1'b1});
        tick(); chk("t5_idle_d", {ENC_DATA, ENC_K}, {8'h50, 1'b0});
        chk("t5_link_drop", LINK_UP, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_align_sym", {ENC_DATA, ENC_K}, {8'hBC, 1'b1});
            chk("t5_align_link", LINK_UP, 1'b0);
        end

        // RESET pulse mid-DATA: packet abandoned without EOP, full preamble follows
        ENABLE = 1'b1; TX_VALID = 1'b1; TX_LAST = 1'b0; TX_DATA = 8'hC1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (ENC_DATA == 8'hFB && ENC_K) found = 1;
        end
        chk("t6_sop_seen", found, 1'b1);
        tick();
        chk("t6_c1", {ENC_DATA, ENC_K}, {8'hC1, 1'b0});
        chk("t6_rdy_data", TX_READY, 1'b1);
        RESET = 1'b1; TX_DATA = 8'hC2;
        #1;
        chk("t6_rdy_in_reset", TX_READY, 1'b0);
        tick();
        chk("t6_rst_sym", {ENC_DATA, ENC_K}, {8'hBC, 1'b1});
        chk("t6_rst_rdy", TX_READY, 1'b0);
        chk("t6_rst_link", LINK_UP, 1'b0);
        chk("t6_rst_und", UNDERRUN, 1'b0);
        RESET = 1'b0; TX_VALID = 1'b0;
        for (int e = 1; e <= ACOUNT; e++) begin
            tick();
            chk("t6_pre_sym", {ENC_DATA, ENC_K}, {8'hBC, 1'b1});
        end
        tick();
        chk("t6_first_d", {ENC_DATA, ENC_K}, {8'h50, 1'b0});
        chk("t6_link_up", LINK_UP, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
